// File: rtl/router_pe_port_if.sv
// router_pe_port_if: NIC link and router-core signals of the PE port
interface router_pe_port_if #(
    parameter int DW = 64,
    parameter int CW = 16
);
    logic          net_polarity;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;
    logic          core_inj_vld;
    logic [DW-1:0] core_inj_data;
    logic          core_inj_gnt;
    logic          core_ej_wr;
    logic [DW-1:0] core_ej_data;
    logic          core_ej_rdy;
    logic          vc_err;
    logic [CW-1:0] inj_cnt;
    logic [CW-1:0] ej_cnt;

    modport slave (
        output net_polarity, net_ro, net_si, net_di, core_inj_vld, core_inj_data,
               core_ej_rdy, vc_err, inj_cnt, ej_cnt,
        input  net_so, net_do, net_ri, core_inj_gnt, core_ej_wr, core_ej_data
    );

    modport master (
        input  net_polarity, net_ro, net_si, net_di, core_inj_vld, core_inj_data,
               core_ej_rdy, vc_err, inj_cnt, ej_cnt,
        output net_so, net_do, net_ri, core_inj_gnt, core_ej_wr, core_ej_data
    );
endinterface

// File: rtl/router_pe_port.sv
// router_pe_port: router-side PE port with one buffer per VC in each direction and polarity generation
module router_pe_port #(
    parameter int DW = 64,
    parameter int CW = 16
) (
    input logic               clk,
    input logic               reset,
    router_pe_port_if.slave   bus
);
    logic          p;
    logic          ext;
    logic [1:0]    inj_full;
    logic [1:0]    ej_full;
    logic [DW-1:0] inj_buf [2];
    logic [DW-1:0] ej_buf [2];
    logic          inj_acc;
    logic          inj_bad;
    logic          inj_take;
    logic          ej_wr;
    logic          ej_out;
    logic [CW-1:0] inj_cnt;
    logic [CW-1:0] ej_cnt;
    logic          vc_err;

    // NIC side works on the link VC ~p, core side on the internal VC p, so the two never share a buffer
    always_comb begin
        ext      = ~p;
        inj_acc  = bus.net_so && !inj_full[ext] && (bus.net_do[DW-1] == ext);
        inj_bad  = bus.net_so && (bus.net_do[DW-1] != ext);
        inj_take = inj_full[p] && bus.core_inj_gnt;
        ej_wr    = bus.core_ej_wr && !ej_full[p];
        ej_out   = ej_full[ext] && bus.net_ri;
    end

    assign bus.net_polarity  = p;
    assign bus.net_ro        = !inj_full[ext];
    assign bus.net_si        = ej_out;
    assign bus.net_di        = ej_out ? ej_buf[ext] : '0;
    assign bus.core_inj_vld  = inj_full[p];
    assign bus.core_inj_data = inj_buf[p];
    assign bus.core_ej_rdy   = !ej_full[p];
    assign bus.vc_err        = vc_err;
    assign bus.inj_cnt       = inj_cnt;
    assign bus.ej_cnt        = ej_cnt;

    // polarity, buffer fill/drain, sticky VC error and wrapping packet counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p        <= 1'b0;
            inj_full <= '0;
            ej_full  <= '0;
            inj_buf  <= '{default: '0};
            ej_buf   <= '{default: '0};
            inj_cnt  <= '0;
            ej_cnt   <= '0;
            vc_err   <= 1'b0;
        end else begin
            p <= ~p;
            if (inj_acc) begin
                inj_buf[ext]  <= bus.net_do;
                inj_full[ext] <= 1'b1;
                inj_cnt       <= inj_cnt + CW'(1);
            end
            if (inj_bad)
                vc_err <= 1'b1;
            if (inj_take)
                inj_full[p] <= 1'b0;
            if (ej_wr) begin
                ej_buf[p]  <= bus.core_ej_data;
                ej_full[p] <= 1'b1;
            end
            if (ej_out) begin
                ej_full[ext] <= 1'b0;
                ej_cnt       <= ej_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_pe_port.sv
// tb_router_pe_port: directed stimulus with queue scoreboards for injection and ejection packets
module tb_router_pe_port;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic ep = 1'b0;
    logic run = 1'b0;
    logic [63:0] inj_q[$];
    logic [63:0] ej_q[$];

    localparam logic [63:0] A  = 64'h8000_0000_DEAD_BEEF;
    localparam logic [63:0] A2 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] A3 = 64'h8000_0000_0000_0002;
    localparam logic [63:0] B0 = 64'h0000_0000_CAFE_F00D;
    localparam logic [63:0] BD = 64'h0000_0000_0000_1234;
    localparam logic [63:0] C  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D  = 64'hFEED_FACE_0000_0042;
    localparam logic [63:0] E  = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] F1 = 64'h8000_0000_0000_00F1;
    localparam logic [63:0] F0 = 64'h0000_0000_0000_00F0;
    localparam logic [63:0] G0 = 64'h0000_0000_0000_00C0;
    localparam logic [63:0] G1 = 64'h0000_0000_0000_00C1;

    router_pe_port_if #(.DW(64), .CW(16)) bus ();
    router_pe_port #(.DW(64), .CW(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (run) ep = ~ep;
        chk("polarity", {63'd0, bus.net_polarity}, {63'd0, ep});
    endtask

    // pops an expected packet whenever the DUT completes a transfer on either side
    always @(negedge clk) begin
        if (bus.core_inj_vld && bus.core_inj_gnt) begin
            if (inj_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL inj_unexpected: got %h, expected no packet", bus.core_inj_data);
            end else chk("inj_data", bus.core_inj_data, inj_q.pop_front());
        end
        if (bus.net_si) begin
            if (ej_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ej_unexpected: got %h, expected no packet", bus.net_di);
            end else chk("ej_data", bus.net_di, ej_q.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        bus.net_so = 1'b0;
        bus.net_do = '0;
        bus.net_ri = 1'b1;
        bus.core_inj_gnt = 1'b0;
        bus.core_ej_wr = 1'b0;
        bus.core_ej_data = '0;
        repeat (3) step();
        reset = 1'b1;
        run = 1'b1;
        chk("rst_ro", bus.net_ro, 1);
        chk("rst_si", bus.net_si, 0);
        chk("rst_di", bus.net_di, 0);
        chk("rst_vld", bus.core_inj_vld, 0);
        chk("rst_inj_data", bus.core_inj_data, 0);
        chk("rst_ej_rdy", bus.core_ej_rdy, 1);
        chk("rst_vc_err", bus.vc_err, 0);
        chk("rst_inj_cnt", bus.inj_cnt, 0);
        chk("rst_ej_cnt", bus.ej_cnt, 0);
        step(); step(); step();
        step();
        // VC1 injection in a p=0 cycle
        chk("ro_free", bus.net_ro, 1);
        bus.net_so = 1'b1; bus.net_do = A; inj_q.push_back(A);
        step();
        bus.net_so = 1'b0;
        chk("inj_vld", bus.core_inj_vld, 1);
        chk("inj_vis_data", bus.core_inj_data, A);
        chk("inj_cnt1", bus.inj_cnt, 1);
        bus.core_inj_gnt = 1'b1;
        step();
        bus.core_inj_gnt = 1'b0;
        step();
        chk("inj_vld_clr", bus.core_inj_vld, 0);
        // VC1 full blocks further VC1 offers until granted
        step();
        bus.net_so = 1'b1; bus.net_do = A2; inj_q.push_back(A2);
        step();
        bus.net_so = 1'b0;
        chk("inj_cnt2", bus.inj_cnt, 2);
        step();
        chk("ro_blocked", bus.net_ro, 0);
        bus.net_so = 1'b1; bus.net_do = A3;
        step();
        bus.net_so = 1'b0;
        chk("inj_cnt_held", bus.inj_cnt, 2);
        chk("inj_vld_held", bus.core_inj_vld, 1);
        bus.core_inj_gnt = 1'b1;
        step();
        bus.core_inj_gnt = 1'b0;
        chk("ro_freed", bus.net_ro, 1);
        bus.net_so = 1'b1; bus.net_do = A3; inj_q.push_back(A3);
        step();
        chk("inj_cnt3", bus.inj_cnt, 3);
        chk("inj_a3", bus.core_inj_data, A3);
        bus.core_inj_gnt = 1'b1;
        bus.net_do = B0; inj_q.push_back(B0);
        step();
        bus.net_so = 1'b0;
        chk("inj_cnt4", bus.inj_cnt, 4);
        chk("inj_vld_vc0", bus.core_inj_vld, 1);
        chk("inj_b0", bus.core_inj_data, B0);
        step();
        bus.core_inj_gnt = 1'b0;
        chk("inj_vld_vc0_clr", bus.core_inj_vld, 0);
        // wrong-VC offer is dropped
        step();
        bus.net_so = 1'b1; bus.net_do = BD;
        step();
        bus.net_so = 1'b0;
        chk("vc_err_set", bus.vc_err, 1);
        chk("inj_cnt_drop", bus.inj_cnt, 4);
        chk("drop_vld1", bus.core_inj_vld, 0);
        step();
        chk("drop_vld0", bus.core_inj_vld, 0);
        chk("vc_err_sticky", bus.vc_err, 1);
        // ejection with and without NIC space
        step();
        chk("ej_rdy", bus.core_ej_rdy, 1);
        bus.core_ej_wr = 1'b1; bus.core_ej_data = C; ej_q.push_back(C);
        step();
        bus.core_ej_wr = 1'b0;
        chk("ej_si", bus.net_si, 1);
        chk("ej_di", bus.net_di, C);
        step();
        chk("ej_si_clr", bus.net_si, 0);
        chk("ej_di_zero", bus.net_di, 0);
        chk("ej_cnt1", bus.ej_cnt, 1);
        bus.net_ri = 1'b0;
        bus.core_ej_wr = 1'b1; bus.core_ej_data = D; ej_q.push_back(D);
        step();
        bus.core_ej_wr = 1'b0;
        chk("ej_hold_si", bus.net_si, 0);
        chk("ej_hold_di", bus.net_di, 0);
        step();
        chk("ej_rdy_full", bus.core_ej_rdy, 0);
        bus.core_ej_wr = 1'b1; bus.core_ej_data = E;
        step();
        bus.core_ej_wr = 1'b0;
        chk("ej_hold_si2", bus.net_si, 0);
        bus.net_ri = 1'b1;
        #1;
        chk("ej_release_si", bus.net_si, 1);
        chk("ej_release_di", bus.net_di, D);
        step();
        chk("ej_cnt2", bus.ej_cnt, 2);
        chk("ej_rdy_again", bus.core_ej_rdy, 1);
        step();
        chk("ej_ignored_wr", bus.net_si, 0);
        // fill both directions then reset mid-cycle
        bus.net_ri = 1'b0;
        bus.net_so = 1'b1; bus.net_do = F1;
        bus.core_ej_wr = 1'b1; bus.core_ej_data = G0;
        step();
        bus.net_do = F0; bus.core_ej_data = G1;
        step();
        bus.net_so = 1'b0; bus.core_ej_wr = 1'b0;
        chk("fill_vld", bus.core_inj_vld, 1);
        chk("fill_ej_rdy", bus.core_ej_rdy, 0);
        chk("fill_inj_cnt", bus.inj_cnt, 6);
        #2;
        reset = 1'b0; run = 1'b0; ep = 1'b0;
        #1;
        chk("arst_vld", bus.core_inj_vld, 0);
        chk("arst_ej_rdy", bus.core_ej_rdy, 1);
        chk("arst_ro", bus.net_ro, 1);
        chk("arst_inj_cnt", bus.inj_cnt, 0);
        chk("arst_ej_cnt", bus.ej_cnt, 0);
        chk("arst_vc_err", bus.vc_err, 0);
        chk("arst_inj_data", bus.core_inj_data, 0);
        step();
        reset = 1'b1; run = 1'b1;
        bus.net_ri = 1'b1; bus.core_inj_gnt = 1'b1;
        repeat (6) begin
            step();
            chk("post_rst_si", bus.net_si, 0);
            chk("post_rst_vld", bus.core_inj_vld, 0);
        end
        bus.core_inj_gnt = 1'b0;
        chk("inj_q_empty", inj_q.size(), 0);
        chk("ej_q_empty", ej_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
